mips_mem_io: RTL and testbench

//  Memory/IO slave directly downstream of the multicycle MIPS core.

---
 rtl/mips_mem_io.sv | 118 +++++++++++
 tb/tb_mips_mem_io.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_io.sv
// Memory/IO slave for the multicycle MIPS core: unified RAM plus an IO page with a TX FIFO and status.
// Define MEMIO_CYCLE_COUNTER_EN to add the free-running cycle counter at IO offset 0x08.
module mips_mem_io #(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] FULL_CNT = (FW+1)'(FIFO_DEPTH);

  logic [31:0]   r_mem  [MEM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_rd_ptr;
  logic [FW-1:0] r_wr_ptr;
  logic [FW:0]   r_count;
  logic          r_ovf;

  logic          w_io_sel;
  logic [7:0]    w_off;
  logic [AW-1:0] w_idx;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_status_wr;

  assign w_io_sel    = (adr[31:8] == 24'hFFFFFF);
  assign w_off       = adr[7:0];
  assign w_idx       = adr[AW+1:2];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = tx_valid & tx_ready;
  assign w_push_req  = memwrite & w_io_sel & (w_off == 8'h00);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_status_wr = memwrite & w_io_sel & (w_off == 8'h04);

  assign tx_valid = ~w_empty;
  assign tx_data  = r_fifo[r_rd_ptr];

  // Storage arrays are deliberately outside reset.
  always_ff @(posedge clk) begin
    if (memwrite && !w_io_sel)
      r_mem[w_idx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wr_ptr] <= writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + FW'(1);
      if (w_push)
        r_wr_ptr <= r_wr_ptr + FW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FW+1)'(1);
        2'b01:   r_count <= r_count - (FW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (w_status_wr)
        r_ovf <= 1'b0;
    end
  end

`ifdef MEMIO_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;
  logic        w_cycle_wr;

  assign w_cycle_wr = memwrite & w_io_sel & (w_off == 8'h08);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cycle <= '0;
    else if (w_cycle_wr)
      r_cycle <= '0;
    else
      r_cycle <= r_cycle + 32'd1;
  end
`endif

  always_comb begin
    readdata = '0;
    if (!w_io_sel) begin
      readdata = r_mem[w_idx];
    end else begin
      case (w_off)
        8'h04:   readdata = {16'h0000, 8'(r_count), 5'b00000, r_ovf, w_full, w_empty};
`ifdef MEMIO_CYCLE_COUNTER_EN
        8'h08:   readdata = r_cycle;
`endif
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_io.sv
// Bench for mips_mem_io: directed scenarios plus randomized traffic against a queue-based model.
module tb_mips_mem_io;

  localparam int MEM_WORDS  = 64;
  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] IO_TX  = 32'hFFFFFF00;
  localparam logic [31:0] IO_ST  = 32'hFFFFFF04;
  localparam logic [31:0] IO_CYC = 32'hFFFFFF08;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  mips_mem_io #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .adr(adr), .writedata(writedata), .memwrite(memwrite),
    .readdata(readdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  bit          m_ovf;
  logic [31:0] m_cyc;
  logic [31:0] m_ram [MEM_WORDS];
  bit          m_known [MEM_WORDS];
  logic [7:0]  popped[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    v = 32'h0;
    if (a[31:8] != 24'hFFFFFF) begin
      v = m_ram[a[7:2]];
      return m_known[a[7:2]];
    end
    if (a[7:0] == 8'h04)
      v = (m_q.size() << 8) | (m_ovf << 2) | ((m_q.size() == FIFO_DEPTH) << 1) | (m_q.size() == 0);
`ifdef MEMIO_CYCLE_COUNTER_EN
    else if (a[7:0] == 8'h08)
      v = m_cyc;
`endif
    return 1'b1;
  endfunction

  // One clock: apply inputs, check pre-edge outputs, then advance the model at the edge.
  task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    logic [31:0] ev;
    bit          ok;
    bit          pop;
    memwrite = we; adr = a; writedata = wd; tx_ready = rdy;
    #1;
    chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, m_q[0]});
    ok = model_read(a, ev);
    if (ok) chk("readdata", readdata, ev);
    @(posedge clk);
    pop = (m_q.size() != 0) && rdy;
    if (pop) popped.push_back(m_q.pop_front());
    m_cyc = m_cyc + 1;
    if (we) begin
      if (a[31:8] != 24'hFFFFFF) begin
        m_ram[a[7:2]] = wd;
        m_known[a[7:2]] = 1'b1;
      end else if (a[7:0] == 8'h00) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(wd[7:0]);
        else m_ovf = 1'b1;
      end else if (a[7:0] == 8'h04) begin
        m_ovf = 1'b0;
      end else if (a[7:0] == 8'h08) begin
        m_cyc = 32'h0;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_cyc = 32'h0;
  endtask

  task automatic drain(input int n);
    popped.delete();
    for (int i = 0; i < n; i++) cyc(1'b0, IO_ST, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] r1;
    for (int i = 0; i < MEM_WORDS; i++) m_known[i] = 1'b0;
    reset = 1'b0; memwrite = 1'b0; adr = IO_ST; writedata = 32'h0; tx_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_status", readdata, 32'h00000001);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    // RAM write, read and alias
    cyc(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    cyc(1'b0, 32'h10, 32'h0, 1'b0);
    adr = 32'h10 + 4 * MEM_WORDS; #1;
    chk("ram_alias", readdata, 32'hDEADBEEF);

    // FIFO ordering
    cyc(1'b1, IO_TX, 32'h41, 1'b0);
    cyc(1'b1, IO_TX, 32'h42, 1'b0);
    cyc(1'b1, IO_TX, 32'h43, 1'b0);
    adr = IO_ST; #1;
    chk("status_cnt3", readdata, 32'h00000300);
    drain(4);
    chk("order", {popped[0], popped[1], popped[2]}, 32'h00414243);
    chk("empty_after", readdata, 32'h00000001);

    // Overflow
    for (int i = 1; i <= 9; i++) cyc(1'b1, IO_TX, i, 1'b0);
    adr = IO_ST; #1;
    chk("status_full_ovf", readdata, 32'h00000806);
    drain(9);
    chk("drain_cnt", popped.size(), 8);
    chk("drain_last", {24'b0, popped[7]}, 32'h08);
    cyc(1'b1, IO_ST, 32'h0, 1'b0);
    adr = IO_ST; #1;
    chk("ovf_clear", readdata, 32'h00000001);

    // Full with same-cycle pop
    for (int i = 0; i < FIFO_DEPTH; i++) cyc(1'b1, IO_TX, 32'h10 + i, 1'b0);
    cyc(1'b1, IO_TX, 32'hAA, 1'b1);
    adr = IO_ST; #1;
    chk("full_pop_push", readdata, 32'h00000802);
    drain(9);
    chk("aa_last", {24'b0, popped[popped.size()-1]}, 32'hAA);

    // Reset mid-drain
    for (int i = 0; i < 5; i++) cyc(1'b1, IO_TX, 32'h60 + i, 1'b0);
    cyc(1'b0, IO_ST, 32'h0, 1'b1);
    cyc(1'b0, IO_ST, 32'h0, 1'b1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_valid", {31'b0, tx_valid}, 32'h0);
    chk("mid_rst_status", readdata, 32'h00000001);
    adr = 32'h10; #1;
    chk("mid_rst_ram", readdata, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    cyc(1'b1, IO_TX, 32'h77, 1'b0);
    cyc(1'b0, IO_ST, 32'h0, 1'b1);

    // Cycle counter
    cyc(1'b0, IO_CYC, 32'h0, 1'b0);
    r1 = readdata;
    for (int i = 0; i < 7; i++) cyc(1'b0, IO_CYC, 32'h0, 1'b0);
    adr = IO_CYC; #1;
`ifdef MEMIO_CYCLE_COUNTER_EN
    chk("cyc_diff", readdata - r1, 32'd7);
    cyc(1'b1, IO_CYC, 32'h1234, 1'b0);
    adr = IO_CYC; #1;
    chk("cyc_cleared", readdata, 32'h0);
`else
    chk("cyc_absent", readdata | r1, 32'h0);
    cyc(1'b1, IO_CYC, 32'h1234, 1'b0);
    adr = IO_CYC; #1;
    chk("cyc_absent_wr", readdata, 32'h0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0, 1:    a = $urandom & 32'h00000FFC;
        2:       a = IO_TX;
        3:       a = IO_ST;
        4:       a = IO_CYC;
        default: a = 32'hFFFFFF0C;
      endcase
      cyc($urandom_range(0, 99) < 45, a, $urandom, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
